// File: rtl/rr_arb_pkg.sv
// Shared constants and helpers for the 4-requester round-robin arbiter.
// Optional per-requester transfer counters are enabled by RR_ARB_STATS_EN.
package rr_arb_pkg;

  localparam int unsigned N_REQ = 4;
  localparam int unsigned IDX_W = 2;
  localparam int unsigned CNT_W = 16;

  // One-hot grant to its binary index; an all-zero grant maps to 0.
  function automatic logic [IDX_W-1:0] onehot_to_idx(input logic [N_REQ-1:0] onehot);
    logic [IDX_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (onehot[i]) idx = idx | IDX_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/rr_arb_onehot_4to1_pick4.sv
// Combinational rotate-priority picker: first valid index at or after ptr wins.
module rr_pick4
  import rr_arb_pkg::*;
(
  input  logic [N_REQ-1:0] valid,
  input  logic [IDX_W-1:0] ptr,
  output logic [N_REQ-1:0] grant
);

  logic             found;
  logic [IDX_W-1:0] idx;

  always_comb begin
    grant = '0;
    found = 1'b0;
    idx   = '0;
    // idx wraps naturally at IDX_W bits, giving the mod-4 scan order
    for (int i = 0; i < N_REQ; i++) begin
      idx = ptr + IDX_W'(i);
      if (!found && valid[idx]) begin
        grant[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rr_arb_onehot_4to1.sv
// Round-robin 4:1 arbiter feeding a single registered valid/ready output stage.
// Define RR_ARB_STATS_EN to add saturating per-requester transfer counters.
module rr_arb_onehot_4to1
  import rr_arb_pkg::*;
#(
  parameter int unsigned DATA_W = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [N_REQ-1:0]  io_in_valid,
  output logic [N_REQ-1:0]  io_in_ready,
  input  logic [DATA_W-1:0] io_in0,
  input  logic [DATA_W-1:0] io_in1,
  input  logic [DATA_W-1:0] io_in2,
  input  logic [DATA_W-1:0] io_in3,
  output logic              io_out_valid,
  input  logic              io_out_ready,
  output logic [DATA_W-1:0] io_out,
  output logic [N_REQ-1:0]  io_sel,
  output logic              io_busy
`ifdef RR_ARB_STATS_EN
  ,
  output logic [CNT_W-1:0]  io_cnt0,
  output logic [CNT_W-1:0]  io_cnt1,
  output logic [CNT_W-1:0]  io_cnt2,
  output logic [CNT_W-1:0]  io_cnt3
`endif
);

  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic [N_REQ-1:0]  out_src;
  logic [IDX_W-1:0]  ptr;

  logic              accept;
  logic [N_REQ-1:0]  grant;
  logic [DATA_W-1:0] mux_word;
  logic [DATA_W-1:0] in_word [N_REQ];

  assign in_word[0] = io_in0;
  assign in_word[1] = io_in1;
  assign in_word[2] = io_in2;
  assign in_word[3] = io_in3;

  rr_pick4 u_pick (
    .valid (io_in_valid),
    .ptr   (ptr),
    .grant (grant)
  );

  // Output stage can take a word when empty or being drained this cycle
  assign accept      = ~out_valid | io_out_ready;
  assign io_in_ready = accept ? grant : '0;

  // One-hot AND-OR mux
  always_comb begin
    mux_word = '0;
    for (int k = 0; k < N_REQ; k++) begin
      mux_word = mux_word | (in_word[k] & {DATA_W{grant[k]}});
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      out_data  <= '0;
      out_valid <= 1'b0;
      out_src   <= '0;
      ptr       <= '0;
    end else if (accept) begin
      if (|grant) begin
        out_data  <= mux_word;
        out_valid <= 1'b1;
        out_src   <= grant;
        ptr       <= onehot_to_idx(grant) + IDX_W'(1);
      end else begin
        out_valid <= 1'b0;
        out_src   <= '0;
      end
    end
  end

  assign io_out       = out_data;
  assign io_out_valid = out_valid;
  assign io_sel       = out_src;
  assign io_busy      = out_valid & ~io_out_ready;

`ifdef RR_ARB_STATS_EN
  logic [CNT_W-1:0] cnt [N_REQ];

  // Saturating count of completed input transfers per requester
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < N_REQ; i++) cnt[i] <= '0;
    end else begin
      for (int i = 0; i < N_REQ; i++) begin
        if (io_in_valid[i] && io_in_ready[i] && (cnt[i] != '1)) begin
          cnt[i] <= cnt[i] + CNT_W'(1);
        end
      end
    end
  end

  assign io_cnt0 = cnt[0];
  assign io_cnt1 = cnt[1];
  assign io_cnt2 = cnt[2];
  assign io_cnt3 = cnt[3];
`endif

endmodule

// File: tb/tb_rr_arb_onehot_4to1.sv
// Bench for rr_arb_onehot_4to1: directed vector table, random traffic against a
// queue-free reference model, and (with RR_ARB_STATS_EN) counter saturation.
module tb_rr_arb_onehot_4to1;

  logic        clock;
  logic        reset;
  logic [3:0]  io_in_valid;
  logic [3:0]  io_in_ready;
  logic [31:0] in_data [4];
  logic        io_out_valid;
  logic        io_out_ready;
  logic [31:0] io_out;
  logic [3:0]  io_sel;
  logic        io_busy;
`ifdef RR_ARB_STATS_EN
  logic [15:0] io_cnt0, io_cnt1, io_cnt2, io_cnt3;
`endif

  int n_vec = 0;
  int n_err = 0;

  rr_arb_onehot_4to1 dut (
    .clock        (clock),
    .reset        (reset),
    .io_in_valid  (io_in_valid),
    .io_in_ready  (io_in_ready),
    .io_in0       (in_data[0]),
    .io_in1       (in_data[1]),
    .io_in2       (in_data[2]),
    .io_in3       (in_data[3]),
    .io_out_valid (io_out_valid),
    .io_out_ready (io_out_ready),
    .io_out       (io_out),
    .io_sel       (io_sel),
    .io_busy      (io_busy)
`ifdef RR_ARB_STATS_EN
    ,
    .io_cnt0      (io_cnt0),
    .io_cnt1      (io_cnt1),
    .io_cnt2      (io_cnt2),
    .io_cnt3      (io_cnt3)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Directed vectors: pre-edge checks on ready/busy, post-edge on registers
  typedef struct packed {
    logic        rst;
    logic [3:0]  v;
    logic        r;
    logic [3:0]  e_rdy;
    logic        e_busy;
    logic        e_ov;
    logic [3:0]  e_sel;
    logic [31:0] e_out;
  } vec_t;

  localparam logic [31:0] D0 = 32'hCAFE0000;
  localparam logic [31:0] D1 = 32'hCAFE0001;
  localparam logic [31:0] D2 = 32'hCAFE0002;
  localparam logic [31:0] D3 = 32'hCAFE0003;

  vec_t tbl [18];

  task automatic apply_vec(input vec_t t, input int idx);
    @(negedge clock);
    reset        = t.rst;
    io_in_valid  = t.v;
    io_out_ready = t.r;
    #1;
    check($sformatf("vec%0d in_ready", idx), 32'(io_in_ready), 32'(t.e_rdy));
    check($sformatf("vec%0d busy", idx), 32'(io_busy), 32'(t.e_busy));
    @(posedge clock);
    #1;
    check($sformatf("vec%0d out_valid", idx), 32'(io_out_valid), 32'(t.e_ov));
    check($sformatf("vec%0d sel", idx), 32'(io_sel), 32'(t.e_sel));
    check($sformatf("vec%0d out", idx), io_out, t.e_out);
  endtask

  // Reference model: abstract state, recomputed from the arbitration rules
  int          m_ptr;
  bit          m_ov;
  logic [31:0] m_out;
  int          m_src;
  int          m_cnt [4];
  int          wait_cnt [4];
  bit          pend [4];

  function automatic int model_pick(input logic [3:0] v);
    for (int k = 0; k < 4; k++) begin
      int j;
      j = (m_ptr + k) % 4;
      if (v[j]) return j;
    end
    return -1;
  endfunction

  task automatic do_reset();
    @(negedge clock);
    reset       = 1'b1;
    io_in_valid = 4'b0000;
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    m_ptr = 0; m_ov = 1'b0; m_out = '0; m_src = -1;
    for (int k = 0; k < 4; k++) begin
      m_cnt[k] = 0; wait_cnt[k] = 0; pend[k] = 1'b0;
    end
  endtask

  task automatic rnd_cycle(input int cyc);
    bit          acc;
    int          g;
    logic [3:0]  e_rdy;
    logic [3:0]  e_sel;
    @(negedge clock);
    for (int k = 0; k < 4; k++) begin
      if (!pend[k] && $urandom_range(0, 3) != 0) begin
        pend[k]    = 1'b1;
        in_data[k] = $urandom;
      end
      io_in_valid[k] = pend[k];
    end
    io_out_ready = ($urandom_range(0, 3) != 0);
    #1;
    acc   = !m_ov || io_out_ready;
    g     = model_pick(io_in_valid);
    e_rdy = (acc && g >= 0) ? 4'(1 << g) : 4'b0000;
    check($sformatf("rnd%0d in_ready", cyc), 32'(io_in_ready), 32'(e_rdy));
    check($sformatf("rnd%0d busy", cyc), 32'(io_busy), 32'(m_ov && !io_out_ready));
    @(posedge clock);
    #1;
    if (acc) begin
      for (int k = 0; k < 4; k++) if (pend[k]) wait_cnt[k]++;
      if (g >= 0) begin
        m_out = in_data[g];
        m_ov  = 1'b1;
        m_src = g;
        m_ptr = (g + 1) % 4;
        if (m_cnt[g] < 65535) m_cnt[g]++;
        check($sformatf("rnd%0d fairness req%0d", cyc, g), 32'(wait_cnt[g] <= 4), 32'd1);
        wait_cnt[g] = 0;
        pend[g]     = 1'b0;
      end else begin
        m_ov  = 1'b0;
        m_src = -1;
      end
    end
    e_sel = (m_src < 0) ? 4'b0000 : 4'(1 << m_src);
    check($sformatf("rnd%0d out_valid", cyc), 32'(io_out_valid), 32'(m_ov));
    check($sformatf("rnd%0d sel", cyc), 32'(io_sel), 32'(e_sel));
    check($sformatf("rnd%0d out", cyc), io_out, m_out);
`ifdef RR_ARB_STATS_EN
    check($sformatf("rnd%0d cnt0", cyc), 32'(io_cnt0), 32'(m_cnt[0]));
    check($sformatf("rnd%0d cnt1", cyc), 32'(io_cnt1), 32'(m_cnt[1]));
    check($sformatf("rnd%0d cnt2", cyc), 32'(io_cnt2), 32'(m_cnt[2]));
    check($sformatf("rnd%0d cnt3", cyc), 32'(io_cnt3), 32'(m_cnt[3]));
`endif
  endtask

  initial begin
    tbl[0]  = '{1'b0, 4'b1111, 1'b1, 4'b0001, 1'b0, 1'b1, 4'b0001, D0};
    tbl[1]  = '{1'b0, 4'b1111, 1'b1, 4'b0010, 1'b0, 1'b1, 4'b0010, D1};
    tbl[2]  = '{1'b0, 4'b1111, 1'b1, 4'b0100, 1'b0, 1'b1, 4'b0100, D2};
    tbl[3]  = '{1'b0, 4'b1111, 1'b1, 4'b1000, 1'b0, 1'b1, 4'b1000, D3};
    tbl[4]  = '{1'b0, 4'b1111, 1'b1, 4'b0001, 1'b0, 1'b1, 4'b0001, D0};
    tbl[5]  = '{1'b0, 4'b1111, 1'b0, 4'b0000, 1'b1, 1'b1, 4'b0001, D0};
    tbl[6]  = '{1'b0, 4'b1111, 1'b0, 4'b0000, 1'b1, 1'b1, 4'b0001, D0};
    tbl[7]  = '{1'b0, 4'b1111, 1'b0, 4'b0000, 1'b1, 1'b1, 4'b0001, D0};
    tbl[8]  = '{1'b0, 4'b1111, 1'b1, 4'b0010, 1'b0, 1'b1, 4'b0010, D1};
    tbl[9]  = '{1'b0, 4'b0100, 1'b1, 4'b0100, 1'b0, 1'b1, 4'b0100, D2};
    tbl[10] = '{1'b0, 4'b0000, 1'b1, 4'b0000, 1'b0, 1'b0, 4'b0000, D2};
    tbl[11] = '{1'b0, 4'b0001, 1'b1, 4'b0001, 1'b0, 1'b1, 4'b0001, D0};
    tbl[12] = '{1'b0, 4'b1111, 1'b0, 4'b0000, 1'b1, 1'b1, 4'b0001, D0};
    tbl[13] = '{1'b1, 4'b1111, 1'b0, 4'b0000, 1'b1, 1'b0, 4'b0000, 32'h0};
    tbl[14] = '{1'b0, 4'b1111, 1'b1, 4'b0001, 1'b0, 1'b1, 4'b0001, D0};
    tbl[15] = '{1'b0, 4'b1010, 1'b1, 4'b0010, 1'b0, 1'b1, 4'b0010, D1};
    tbl[16] = '{1'b0, 4'b1010, 1'b1, 4'b1000, 1'b0, 1'b1, 4'b1000, D3};
    tbl[17] = '{1'b0, 4'b1010, 1'b0, 4'b0000, 1'b1, 1'b1, 4'b1000, D3};

    reset        = 1'b1;
    io_in_valid  = 4'b0000;
    io_out_ready = 1'b1;
    in_data[0] = D0; in_data[1] = D1; in_data[2] = D2; in_data[3] = D3;
    repeat (2) @(posedge clock);
    #1;
    check("reset out_valid", 32'(io_out_valid), 32'd0);
    check("reset out", io_out, 32'h0);
    check("reset sel", 32'(io_sel), 32'd0);
    @(negedge clock);
    reset = 1'b0;
    #1;
    check("reset in_ready", 32'(io_in_ready), 32'd0);
    check("reset busy", 32'(io_busy), 32'd0);

    for (int i = 0; i < 18; i++) apply_vec(tbl[i], i);

    do_reset();
    for (int c = 0; c < 600; c++) rnd_cycle(c);

`ifdef RR_ARB_STATS_EN
    do_reset();
    @(negedge clock);
    io_in_valid  = 4'b0010;
    io_out_ready = 1'b1;
    repeat (70000) @(posedge clock);
    #1;
    check("sat cnt0", 32'(io_cnt0), 32'h0);
    check("sat cnt1", 32'(io_cnt1), 32'h0000FFFF);
    check("sat cnt2", 32'(io_cnt2), 32'h0);
    check("sat cnt3", 32'(io_cnt3), 32'h0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
